// File: rtl/axi_arp_tx.sv
// ARP payload serializer: takes one descriptor (opcode, target MAC/IP) and streams
// the 28-byte ARP body MSB-first on an 8-bit AXI-Stream master, tlast on byte 27.
module axi_arp_tx #(
    parameter int          DEBUG   = 1,
    parameter logic [23:0] MAC_MSB = 24'h010203,
    parameter logic [23:0] MAC_LSB = 24'h040506,
    parameter logic [15:0] IP_MSB  = 16'hc0a8,
    parameter logic [15:0] IP_LSB  = 16'h0602
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        arp_valid,
    output logic        arp_ready,
    input  logic [15:0] arp_opcode,
    input  logic [47:0] arp_dst_mac,
    input  logic [31:0] arp_dst_ip,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [47:0] SRC_MAC  = {MAC_MSB, MAC_LSB};
    localparam logic [31:0] SRC_IP   = {IP_MSB, IP_LSB};
    localparam logic [4:0]  LAST_IDX = 5'd27;

    // DEBUG only controls simulation-side reporting in the wider codebase.
    if (DEBUG != 0) begin : g_debug
    end

    function automatic logic [7:0] arp_byte(input logic [4:0]  i,
                                            input logic [15:0] op,
                                            input logic [47:0] mac,
                                            input logic [31:0] ip);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'h00;
            5'd1:    b = 8'h01;
            5'd2:    b = 8'h08;
            5'd3:    b = 8'h00;
            5'd4:    b = 8'h06;
            5'd5:    b = 8'h04;
            5'd6:    b = op[15:8];
            5'd7:    b = op[7:0];
            5'd8:    b = SRC_MAC[47:40];
            5'd9:    b = SRC_MAC[39:32];
            5'd10:   b = SRC_MAC[31:24];
            5'd11:   b = SRC_MAC[23:16];
            5'd12:   b = SRC_MAC[15:8];
            5'd13:   b = SRC_MAC[7:0];
            5'd14:   b = SRC_IP[31:24];
            5'd15:   b = SRC_IP[23:16];
            5'd16:   b = SRC_IP[15:8];
            5'd17:   b = SRC_IP[7:0];
            5'd18:   b = mac[47:40];
            5'd19:   b = mac[39:32];
            5'd20:   b = mac[31:24];
            5'd21:   b = mac[23:16];
            5'd22:   b = mac[15:8];
            5'd23:   b = mac[7:0];
            5'd24:   b = ip[31:24];
            5'd25:   b = ip[23:16];
            5'd26:   b = ip[15:8];
            5'd27:   b = ip[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  idx_r, idx_s;
    logic        load_s;
    logic [15:0] op_r;
    logic [47:0] mac_r;
    logic [31:0] ip_r;
    logic        tvalid_r, tlast_r;
    logic [7:0]  tdata_r, data_s;

    // Next-state, next-index and next output byte.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        load_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (arp_valid) begin
                    state_s = S_SEND;
                    idx_s   = 5'd0;
                    load_s  = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = S_IDLE;
                        idx_s   = 5'd0;
                    end else begin
                        idx_s = idx_r + 5'd1;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = S_IDLE;
                idx_s   = 5'd0;
            end
        endcase
        // Byte 0 is a constant, so the fields still being latched on the accept edge are never needed here.
        if (state_s == S_SEND) begin
            data_s = arp_byte(idx_s, op_r, mac_r, ip_r);
        end else begin
            data_s = 8'h00;
        end
    end

    // State, index, latched descriptor and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_r  <= S_IDLE;
            idx_r    <= 5'd0;
            op_r     <= 16'h0000;
            mac_r    <= 48'h0;
            ip_r     <= 32'h0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tdata_r  <= 8'h00;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            if (load_s) begin
                op_r  <= arp_opcode;
                mac_r <= arp_dst_mac;
                ip_r  <= arp_dst_ip;
            end
            tvalid_r <= (state_s == S_SEND);
            tlast_r  <= (state_s == S_SEND) && (idx_s == LAST_IDX);
            tdata_r  <= data_s;
        end
    end

    assign arp_ready     = (state_r == S_IDLE);
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tlast  = tlast_r;

endmodule

// File: tb/tb_axi_arp_tx.sv
// Directed self-checking bench for axi_arp_tx: frame content, latency, backpressure,
// mid-frame input changes, reset abort and back-to-back descriptors.
module tb_axi_arp_tx;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        arp_valid;
    logic        arp_ready;
    logic [15:0] arp_opcode;
    logic [47:0] arp_dst_mac;
    logic [31:0] arp_dst_ip;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_frame [28];

    axi_arp_tx dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .arp_valid     (arp_valid),
        .arp_ready     (arp_ready),
        .arp_opcode    (arp_opcode),
        .arp_dst_mac   (arp_dst_mac),
        .arp_dst_ip    (arp_dst_ip),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected frame with the default station identity 01:02:03:04:05:06 / c0a80602.
    task automatic build(input logic [15:0] op, input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0] hdr [18];
        hdr = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hc0, 8'ha8, 8'h06, 8'h02};
        for (int i = 0; i < 18; i++) exp_frame[i] = hdr[i];
        exp_frame[6] = op[15:8];
        exp_frame[7] = op[7:0];
        for (int i = 0; i < 6; i++) exp_frame[18 + i] = mac[47 - 8 * i -: 8];
        for (int i = 0; i < 4; i++) exp_frame[24 + i] = ip[31 - 8 * i -: 8];
    endtask

    // Called right after a negedge; returns just after the negedge that follows acceptance.
    task automatic send(input logic [15:0] op, input logic [47:0] mac, input logic [31:0] ip,
                        input bit hold);
        arp_valid   = 1'b1;
        arp_opcode  = op;
        arp_dst_mac = mac;
        arp_dst_ip  = ip;
        #1;
        chk("ready_before_accept", {63'd0, arp_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) arp_valid = 1'b0;
    endtask

    // bp: 0 = tready always high, 1 = stall pattern; abort_at >= 0 resets after that many beats;
    // mid = change descriptor inputs after beat 5.
    task automatic recv(input string tag, input int bp, input int abort_at, input bit mid);
        int   k = 0;
        int   cyc = 0;
        bit   first = 1'b1;
        bit   stalled = 1'b0;
        logic [7:0] held_d = 8'h00;
        logic       held_l = 1'b0;
        logic [3:0] pat = 4'b1001;
        while (k < 28 && cyc < 200) begin
            if (bp == 0) m_axis_tready = 1'b1;
            else m_axis_tready = pat[cyc % 4] ^ ((cyc % 7) == 5);
            #1;
            if (k == abort_at) begin
                aresetn = 1'b0;
                @(negedge clk);
                #1;
                chk({tag, "_rst_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
                chk({tag, "_rst_tlast"}, {63'd0, m_axis_tlast}, 64'd0);
                chk({tag, "_rst_ready"}, {63'd0, arp_ready}, 64'd1);
                aresetn = 1'b1;
                return;
            end
            if (first) begin
                chk({tag, "_first_valid"}, {63'd0, m_axis_tvalid}, 64'd1);
                first = 1'b0;
            end
            if (stalled) begin
                chk({tag, "_hold_valid"}, {63'd0, m_axis_tvalid}, 64'd1);
                chk({tag, "_hold_data"}, {56'd0, m_axis_tdata}, {56'd0, held_d});
                chk({tag, "_hold_last"}, {63'd0, m_axis_tlast}, {63'd0, held_l});
            end
            if (m_axis_tvalid) chk({tag, "_ready_low"}, {63'd0, arp_ready}, 64'd0);
            if (m_axis_tvalid && m_axis_tready) begin
                chk($sformatf("%s_byte%0d", tag, k), {56'd0, m_axis_tdata}, {56'd0, exp_frame[k]});
                chk($sformatf("%s_last%0d", tag, k), {63'd0, m_axis_tlast}, {63'd0, k == 27});
                k++;
                stalled = 1'b0;
            end else if (m_axis_tvalid) begin
                stalled = 1'b1;
                held_d  = m_axis_tdata;
                held_l  = m_axis_tlast;
            end else begin
                stalled = 1'b0;
            end
            if (mid && k == 5) begin
                arp_dst_ip  = 32'hffffffff;
                arp_dst_mac = 48'hffffffffffff;
                arp_opcode  = 16'hffff;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_beats"}, 64'(k), 64'd28);
        if (bp == 0) chk({tag, "_cycles"}, 64'(cyc), 64'd28);
    endtask

    initial begin
        logic [7:0] reply [28];
        aresetn       = 1'b0;
        arp_valid     = 1'b0;
        arp_opcode    = 16'h0000;
        arp_dst_mac   = 48'h0;
        arp_dst_ip    = 32'h0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
        chk("rst_tdata", {56'd0, m_axis_tdata}, 64'd0);
        chk("rst_ready", {63'd0, arp_ready}, 64'd1);
        aresetn = 1'b1;
        @(negedge clk);

        // Reply with tready high, expected bytes written out by hand.
        reply = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02, 8'h01, 8'h02,
                  8'h03, 8'h04, 8'h05, 8'h06, 8'hc0, 8'ha8, 8'h06, 8'h02, 8'h0a, 8'h0b,
                  8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'hc0, 8'ha8, 8'h06, 8'h01};
        for (int i = 0; i < 28; i++) exp_frame[i] = reply[i];
        send(16'h0002, 48'h0a0b0c0d0e0f, 32'hc0a80601, 1'b0);
        recv("reply", 0, -1, 1'b0);
        #1;
        chk("reply_ready_after", {63'd0, arp_ready}, 64'd1);
        chk("reply_tvalid_after", {63'd0, m_axis_tvalid}, 64'd0);
        @(negedge clk);

        // Same descriptor under backpressure.
        send(16'h0002, 48'h0a0b0c0d0e0f, 32'hc0a80601, 1'b0);
        recv("bp", 1, -1, 1'b0);
        @(negedge clk);

        // Request to an all-zero target MAC.
        build(16'h0001, 48'h000000000000, 32'hc0a80605);
        send(16'h0001, 48'h000000000000, 32'hc0a80605, 1'b0);
        recv("req", 0, -1, 1'b0);
        @(negedge clk);

        // Descriptor inputs changed mid-frame must not reach the stream.
        for (int i = 0; i < 28; i++) exp_frame[i] = reply[i];
        send(16'h0002, 48'h0a0b0c0d0e0f, 32'hc0a80601, 1'b0);
        recv("mid", 1, -1, 1'b1);
        @(negedge clk);

        // Reset after 10 beats, then a clean full frame.
        send(16'h0002, 48'h0a0b0c0d0e0f, 32'hc0a80601, 1'b0);
        recv("abort", 0, 10, 1'b0);
        @(negedge clk);
        send(16'h0002, 48'h0a0b0c0d0e0f, 32'hc0a80601, 1'b0);
        recv("post_rst", 0, -1, 1'b0);
        @(negedge clk);

        // Back-to-back with arp_valid held high: one idle cycle between frames.
        build(16'h0001, 48'h112233445566, 32'hc0a80607);
        send(16'h0001, 48'h112233445566, 32'hc0a80607, 1'b1);
        recv("b2b1", 0, -1, 1'b0);
        #1;
        chk("b2b_gap_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("b2b_gap_ready", {63'd0, arp_ready}, 64'd1);
        @(negedge clk);
        arp_valid = 1'b0;
        recv("b2b2", 0, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
